// File: rtl/ann_operand_loader.sv
// Serial feeder for the single-neuron ANN: packs a byte stream into the input, weight and bias
// operands, pulses start, waits LAT cycles, then presents Result on a valid/ready port.
module ann_operand_loader #(
    parameter int N   = 5,
    parameter int LAT = N + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:N*8-1]   InputVec,
    output logic [0:N*8-1]   WeightVec,
    output logic [7:0]       bias,
    output logic             start,
    input  logic [15:0]      Result,
    output logic [15:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       state_dbg
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        LOAD_X = 3'd0,
        LOAD_W = 3'd1,
        LOAD_B = 3'd2,
        FIRE   = 3'd3,
        WAIT   = 3'd4,
        OUT    = 3'd5
    } state_t;

    // Handshakes: a byte moves on a rising edge when in_valid & in_ready; a result moves when
    // res_valid & res_ready. Neither valid is withdrawn before its transfer.

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:N*8-1]   x_q, x_d;
    logic [0:N*8-1]   w_q, w_d;
    logic [7:0]       b_q, b_d;
    logic             start_q, start_d;
    logic [15:0]      res_q, res_d;
    logic             rv_q, rv_d;
    logic             xfer;

    assign in_ready  = !rst && (state_q == LOAD_X || state_q == LOAD_W || state_q == LOAD_B);
    assign xfer      = in_valid && in_ready;
    assign InputVec  = x_q;
    assign WeightVec = w_q;
    assign bias      = b_q;
    assign start     = start_q;
    assign res_data  = res_q;
    assign res_valid = rv_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        start_d = 1'b0;
        res_d   = res_q;
        rv_d    = rv_q;
        case (state_q)
            LOAD_X: begin
                if (xfer) begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_q == IW'(k)) x_d[8*k +: 8] = in_data;
                    end
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD_W;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_q == IW'(k)) w_d[8*k +: 8] = in_data;
                    end
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            LOAD_B: begin
                // start is raised on entry to FIRE so it is high exactly for the FIRE cycle
                if (xfer) begin
                    b_d     = in_data;
                    start_d = 1'b1;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    res_d   = Result;
                    rv_d    = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = LOAD_X;
                end
            end
            default: state_d = LOAD_X;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_X;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
            start_q <= start_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

endmodule
